// File: rtl/rca_config_unit_pkg.sv
// Shared types and sizing for the RCA configuration unit.
// Holds the funct3 opcode enum, FSM state type, table widths and the
// packed per-RCA configuration record.
package rca_config;

  localparam int NUM_RCAS           = 4;
  localparam int NUM_READ_PORTS     = 4;
  localparam int NUM_WRITE_PORTS    = 4;
  localparam int NUM_GRID_MUXES     = 72;
  localparam int GRID_MUX_INPUTS    = 8;
  localparam int NUM_IO_UNITS       = 8;
  localparam int IO_UNIT_MUX_INPUTS = 12;

  localparam int GRID_SEL_W = $clog2(GRID_MUX_INPUTS);
  localparam int IO_SEL_W   = $clog2(IO_UNIT_MUX_INPUTS);
  localparam int RES_SEL_W  = $clog2(NUM_IO_UNITS);
  localparam int REG_ADDR_W = 5;

  localparam int MAX_PORTS  = (NUM_READ_PORTS > NUM_WRITE_PORTS) ? NUM_READ_PORTS : NUM_WRITE_PORTS;
  localparam int PORT_W     = $clog2(MAX_PORTS);
  localparam int WP_W       = $clog2(NUM_WRITE_PORTS);
  localparam int IO_IDX_W   = $clog2(NUM_IO_UNITS);
  localparam int GRID_IDX_W = $clog2(NUM_GRID_MUXES);
  localparam int RCA_W      = $clog2(NUM_RCAS);
  // Wide enough for a register address or a full io_input_use mask.
  localparam int VAL_W      = (NUM_IO_UNITS > REG_ADDR_W) ? NUM_IO_UNITS : REG_ADDR_W;

  typedef enum logic [2:0] {
    F3_RSVD0      = 3'b000,
    F3_CPU_REG    = 3'b001,
    F3_GRID_MUX   = 3'b010,
    F3_IO_MUX     = 3'b011,
    F3_RESULT_MUX = 3'b100,
    F3_IO_USE     = 3'b101,
    F3_RSVD6      = 3'b110,
    F3_RSVD7      = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_RESP} state_e;

  // Per-RCA configuration; cpu_reg_addr is [fb][dst][port].
  typedef struct packed {
    logic [1:0][1:0][MAX_PORTS-1:0][REG_ADDR_W-1:0] cpu_reg_addr;
    logic [1:0][NUM_WRITE_PORTS-1:0][RES_SEL_W-1:0] result_mux_sel;
    logic [NUM_IO_UNITS-1:0]                        io_input_use;
  } rca_cfg_t;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } issue_t;

endpackage

// File: rtl/rca_config_unit_if.sv
// Issue / done handshake bundle between the CPU side and the config unit.
interface rca_config_unit_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_funct3;
  logic [6:0]  issue_funct7;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic        done_valid;
  logic        done_ready;
  logic        done_error;
  logic [31:0] done_data;

  modport master (
    output issue_valid, issue_funct3, issue_funct7, issue_rs1, issue_rs2, done_ready,
    input  issue_ready, done_valid, done_error, done_data
  );

  modport slave (
    input  issue_valid, issue_funct3, issue_funct7, issue_rs1, issue_rs2, done_ready,
    output issue_ready, done_valid, done_error, done_data
  );
endinterface

// File: rtl/rca_config_decode.sv
// Combinational decode of a captured config instruction into target table,
// RCA id, index, value and a range-check error flag.
module rca_config_decode
  import rca_config::*;
(
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           rs1,
  input  logic [31:0]           rs2,
  output funct3_e               kind,
  output logic [RCA_W-1:0]      rca_id,
  output logic [GRID_IDX_W-1:0] index,
  output logic                  fb,
  output logic                  dst,
  output logic [VAL_W-1:0]      value,
  output logic                  error
);

  logic rca_oob;

  // Field extraction and range checks per instruction type.
  always_comb begin
    kind    = funct3_e'(funct3);
    rca_id  = funct7[RCA_W-1:0];
    index   = '0;
    fb      = 1'b0;
    dst     = 1'b0;
    value   = '0;
    error   = 1'b0;
    rca_oob = (32'(funct7) >= NUM_RCAS);
    case (kind)
      F3_CPU_REG: begin
        index = GRID_IDX_W'(rs1[2:0]);
        dst   = rs1[3];
        fb    = rs1[4];
        value = VAL_W'(rs2[4:0]);
        error = rca_oob || (32'(rs1[2:0]) >= (rs1[3] ? NUM_WRITE_PORTS : NUM_READ_PORTS));
      end
      F3_GRID_MUX: begin
        index = rs1[GRID_IDX_W-1:0];
        value = rs2[VAL_W-1:0];
        error = (rs1 >= NUM_GRID_MUXES) || (rs2 >= GRID_MUX_INPUTS);
      end
      F3_IO_MUX: begin
        index = rs1[GRID_IDX_W-1:0];
        value = rs2[VAL_W-1:0];
        error = (rs1 >= NUM_IO_UNITS) || (rs2 >= IO_UNIT_MUX_INPUTS);
      end
      F3_RESULT_MUX: begin
        index = GRID_IDX_W'(rs1[2:0]);
        fb    = rs1[3];
        value = rs2[VAL_W-1:0];
        error = rca_oob || (32'(rs1[2:0]) >= NUM_WRITE_PORTS) || (rs2 >= NUM_IO_UNITS);
      end
      F3_IO_USE: begin
        value = VAL_W'(rs1[NUM_IO_UNITS-1:0]);
        error = rca_oob;
      end
      default: error = 1'b1;
    endcase
  end

endmodule

// File: rtl/rca_config_unit.sv
// RCA configuration unit: accepts one config instruction at a time, waits
// until the targeted RCA(s) are idle, writes one table field and responds.
// Optional feature: define RCA_CONFIG_READBACK_EN to return the field's
// pre-write value on done_data (otherwise done_data is tied to 0).
module rca_config_unit
  import rca_config::*;
(
  input  logic                  clk,
  input  logic                  rst,
  rca_config_unit_if.slave      bus,
  input  logic [NUM_RCAS-1:0]   rca_busy,
  output logic [REG_ADDR_W-1:0] cpu_reg_addr   [NUM_RCAS][2][2][MAX_PORTS],
  output logic [GRID_SEL_W-1:0] grid_mux_sel   [NUM_GRID_MUXES],
  output logic [IO_SEL_W-1:0]   io_mux_sel     [NUM_IO_UNITS],
  output logic [RES_SEL_W-1:0]  result_mux_sel [NUM_RCAS][2][NUM_WRITE_PORTS],
  output logic [NUM_IO_UNITS-1:0] io_input_use [NUM_RCAS]
);

  state_e   state_q, state_d;
  issue_t   issue_q, issue_d;
  rca_cfg_t cfg_q [NUM_RCAS];
  rca_cfg_t cfg_d [NUM_RCAS];
  logic [NUM_GRID_MUXES-1:0][GRID_SEL_W-1:0] grid_q, grid_d;
  logic [NUM_IO_UNITS-1:0][IO_SEL_W-1:0]     io_q, io_d;
  logic     err_q, err_d;

  funct3_e                dec_kind;
  logic [RCA_W-1:0]       dec_rca;
  logic [GRID_IDX_W-1:0]  dec_index;
  logic                   dec_fb, dec_dst, dec_error, target_busy;
  logic [VAL_W-1:0]       dec_value;

  rca_config_decode u_decode (
    .funct3 (issue_q.funct3),
    .funct7 (issue_q.funct7),
    .rs1    (issue_q.rs1),
    .rs2    (issue_q.rs2),
    .kind   (dec_kind),
    .rca_id (dec_rca),
    .index  (dec_index),
    .fb     (dec_fb),
    .dst    (dec_dst),
    .value  (dec_value),
    .error  (dec_error)
  );

  // Global muxes wait for the whole array to drain; per-RCA fields only for their RCA.
  always_comb begin
    target_busy = ((dec_kind == F3_GRID_MUX) || (dec_kind == F3_IO_MUX)) ? (|rca_busy)
                                                                          : rca_busy[dec_rca];
  end

  // Next-state, capture and single-field table write.
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    err_d   = err_q;
    cfg_d   = cfg_q;
    grid_d  = grid_q;
    io_d    = io_q;
    case (state_q)
      S_IDLE: begin
        if (bus.issue_valid) begin
          issue_d = {bus.issue_funct3, bus.issue_funct7, bus.issue_rs1, bus.issue_rs2};
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dec_error) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (!target_busy) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        case (dec_kind)
          F3_CPU_REG:    cfg_d[dec_rca].cpu_reg_addr[dec_fb][dec_dst][dec_index[PORT_W-1:0]] =
                           dec_value[REG_ADDR_W-1:0];
          F3_GRID_MUX:   grid_d[dec_index] = dec_value[GRID_SEL_W-1:0];
          F3_IO_MUX:     io_d[dec_index[IO_IDX_W-1:0]] = dec_value[IO_SEL_W-1:0];
          F3_RESULT_MUX: cfg_d[dec_rca].result_mux_sel[dec_fb][dec_index[WP_W-1:0]] =
                           dec_value[RES_SEL_W-1:0];
          F3_IO_USE:     cfg_d[dec_rca].io_input_use = dec_value[NUM_IO_UNITS-1:0];
          default: ;
        endcase
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.done_ready) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.issue_ready = (state_q == S_IDLE);
  assign bus.done_valid  = (state_q == S_RESP);
  assign bus.done_error  = err_q;

  // Control and configuration tables, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      grid_q  <= '0;
      io_q    <= '0;
      for (int r = 0; r < NUM_RCAS; r++) cfg_q[r] <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      grid_q  <= grid_d;
      io_q    <= io_d;
      for (int r = 0; r < NUM_RCAS; r++) cfg_q[r] <= cfg_d[r];
    end
  end

  // Captured instruction; only meaningful after an accept, so no reset.
  always_ff @(posedge clk) begin
    issue_q <= issue_d;
  end

`ifdef RCA_CONFIG_READBACK_EN
  logic [31:0] data_q, data_d, old_val;

  // Pre-write value of the addressed field, zero-extended.
  always_comb begin
    old_val = '0;
    case (dec_kind)
      F3_CPU_REG:    old_val = 32'(cfg_q[dec_rca].cpu_reg_addr[dec_fb][dec_dst][dec_index[PORT_W-1:0]]);
      F3_GRID_MUX:   old_val = 32'(grid_q[dec_index]);
      F3_IO_MUX:     old_val = 32'(io_q[dec_index[IO_IDX_W-1:0]]);
      F3_RESULT_MUX: old_val = 32'(cfg_q[dec_rca].result_mux_sel[dec_fb][dec_index[WP_W-1:0]]);
      F3_IO_USE:     old_val = 32'(cfg_q[dec_rca].io_input_use);
      default: ;
    endcase
  end

  // Response data: old value on a write, zero on error and after hand-back.
  always_comb begin
    data_d = data_q;
    if (state_q == S_WRITE) data_d = old_val;
    else if ((state_q == S_WAIT) && dec_error) data_d = '0;
    else if ((state_q == S_RESP) && bus.done_ready) data_d = '0;
  end

  // Readback data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign bus.done_data = data_q;
`else
  assign bus.done_data = '0;
`endif

  // Present the packed tables on the unpacked config outputs.
  always_comb begin
    for (int r = 0; r < NUM_RCAS; r++) begin
      io_input_use[r] = cfg_q[r].io_input_use;
      for (int f = 0; f < 2; f++) begin
        for (int w = 0; w < NUM_WRITE_PORTS; w++)
          result_mux_sel[r][f][w] = cfg_q[r].result_mux_sel[f][w];
        for (int d = 0; d < 2; d++)
          for (int p = 0; p < MAX_PORTS; p++)
            cpu_reg_addr[r][f][d][p] = cfg_q[r].cpu_reg_addr[f][d][p];
      end
    end
    for (int g = 0; g < NUM_GRID_MUXES; g++) grid_mux_sel[g] = grid_q[g];
    for (int i = 0; i < NUM_IO_UNITS; i++)   io_mux_sel[i]   = io_q[i];
  end

endmodule
